// File: rtl/lm07_sensor_model_if.sv
// Three-wire LM07 bus bundle: chip select, serial clock, serial data and
// the responder's output enable for the SIO pad.
//   CS      master -> responder, active-low chip select
//   SCK     master -> responder, serial clock, idles low
//   SIO     responder -> master, serial data
//   SIO_OE  responder -> pad, drive SIO when 1, tri-state when 0
interface lm07_sensor_model_if;
   logic CS;
   logic SCK;
   logic SIO;
   logic SIO_OE;

   modport master (output CS, output SCK, input SIO, input SIO_OE);
   modport slave  (input CS, input SCK, output SIO, output SIO_OE);
endinterface

// File: rtl/lm07_sensor_model.sv
// LM07 temperature sensor responder. Takes a snapshot of TEMP_IN (magnitude
// clamped to MAX_MAG) when CS falls and shifts it out MSB-first on SIO. Each
// new bit follows an SCK falling edge, so the master samples it on the next
// SCK rising edge. PAD_BIT fills the rest of the frame. CS and SCK are
// oversampled on SYSCLK, which must run at least 8x the SCK rate.
// Ports:
//   SYSCLK       system clock
//   RSTN         asynchronous active-low reset
//   bus          slave side of the CS/SCK/SIO bus (with SIO_OE)
//   TEMP_IN      {sign, magnitude} temperature source
//   BUSY         a frame is in progress
//   BIT_CNT      SCK rising edges seen in the current frame
//   FRAME_DONE   one-cycle pulse when a complete frame ends
//   FRAME_ABORT  one-cycle pulse when CS rises before FRAME_BITS edges
//   OVERRUN      sticky, set on extra SCK edges, cleared at the next CS fall
module lm07_sensor_model #(
   parameter int   FRAME_BITS = 16,
   parameter int   DATA_BITS  = 8,
   parameter logic PAD_BIT    = 1'b1,
   parameter int   MAX_MAG    = 99
) (
   input  logic                 SYSCLK,
   input  logic                 RSTN,
   lm07_sensor_model_if.slave   bus,
   input  logic [DATA_BITS-1:0] TEMP_IN,
   output logic                 BUSY,
   output logic [4:0]           BIT_CNT,
   output logic                 FRAME_DONE,
   output logic                 FRAME_ABORT,
   output logic                 OVERRUN
);

   localparam logic [4:0]           FRAME_BITS_C = 5'(FRAME_BITS);
   localparam logic [4:0]           DATA_BITS_C  = 5'(DATA_BITS);
   localparam logic [DATA_BITS-2:0] MAX_MAG_C    = (DATA_BITS-1)'(MAX_MAG);
   localparam logic [DATA_BITS-1:0] PAD_WORD_C   = {DATA_BITS{PAD_BIT}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Sign passes through; the magnitude is limited to MAX_MAG.
   function automatic logic [DATA_BITS-1:0] load_word(input logic [DATA_BITS-1:0] t);
      logic [DATA_BITS-2:0] mag;
      mag = t[DATA_BITS-2:0];
      if (mag > MAX_MAG_C) begin
         mag = MAX_MAG_C;
      end else begin
         mag = t[DATA_BITS-2:0];
      end
      return {t[DATA_BITS-1], mag};
   endfunction

   logic                 cs_meta_r, cs_sync_r, cs_hist_r;
   logic                 sck_meta_r, sck_sync_r, sck_hist_r;
   logic [1:0]           sync_vld_r;
   logic                 armed_r;
   logic                 cs_fall_s, cs_rise_s, sck_rise_s, sck_fall_s;

   state_t               state_r, state_nxt_s;
   logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
   logic                 sio_oe_r, sio_oe_nxt_s;
   logic                 busy_r, busy_nxt_s;
   logic [4:0]           bit_cnt_r, bit_cnt_nxt_s;
   logic                 done_r, done_nxt_s;
   logic                 abort_r, abort_nxt_s;
   logic                 overrun_r, overrun_nxt_s;
   logic [4:0]           cnt_inc_s;

   // Synchronizers plus history flops for CS and SCK.
   always_ff @(posedge SYSCLK or negedge RSTN) begin
      if (!RSTN) begin
         cs_meta_r  <= 1'b1;
         cs_sync_r  <= 1'b1;
         cs_hist_r  <= 1'b1;
         sck_meta_r <= 1'b0;
         sck_sync_r <= 1'b0;
         sck_hist_r <= 1'b0;
      end else begin
         cs_meta_r  <= bus.CS;
         cs_sync_r  <= cs_meta_r;
         cs_hist_r  <= cs_sync_r;
         sck_meta_r <= bus.SCK;
         sck_sync_r <= sck_meta_r;
         sck_hist_r <= sck_sync_r;
      end
   end

   // The synchronizer reset value of CS is high. A CS that is already low
   // when reset is released would then look like a falling edge. CS falls are
   // accepted only after a genuinely sampled high CS has been seen.
   always_ff @(posedge SYSCLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_vld_r <= 2'b00;
         armed_r    <= 1'b0;
      end else begin
         sync_vld_r <= {sync_vld_r[0], 1'b1};
         if (sync_vld_r[1] && cs_sync_r) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   assign cs_fall_s  = cs_hist_r & ~cs_sync_r & armed_r;
   assign cs_rise_s  = ~cs_hist_r & cs_sync_r;
   assign sck_rise_s = ~sck_hist_r & sck_sync_r;
   assign sck_fall_s = sck_hist_r & ~sck_sync_r;
   assign cnt_inc_s  = bit_cnt_r + 5'd1;

   // Frame FSM: next state and next values of every registered output.
   always_comb begin
      state_nxt_s   = state_r;
      shift_nxt_s   = shift_r;
      sio_oe_nxt_s  = sio_oe_r;
      busy_nxt_s    = busy_r;
      bit_cnt_nxt_s = bit_cnt_r;
      done_nxt_s    = 1'b0;
      abort_nxt_s   = 1'b0;
      overrun_nxt_s = overrun_r;
      case (state_r)
         ST_IDLE: begin
            sio_oe_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
            if (cs_fall_s) begin
               state_nxt_s   = ST_SHIFT;
               shift_nxt_s   = load_word(TEMP_IN);
               sio_oe_nxt_s  = 1'b1;
               busy_nxt_s    = 1'b1;
               bit_cnt_nxt_s = 5'd0;
               overrun_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cs_rise_s) begin
               state_nxt_s  = ST_IDLE;
               sio_oe_nxt_s = 1'b0;
               busy_nxt_s   = 1'b0;
               abort_nxt_s  = 1'b1;
            end else if (sck_rise_s) begin
               bit_cnt_nxt_s = cnt_inc_s;
               if (cnt_inc_s == FRAME_BITS_C) begin
                  state_nxt_s = ST_DONE;
                  shift_nxt_s = PAD_WORD_C;
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end else if (sck_fall_s) begin
               // The SIO pin is the shift register MSB; past the data bits it is
               // simply held at the pad value.
               if (bit_cnt_r < DATA_BITS_C) begin
                  shift_nxt_s = {shift_r[DATA_BITS-2:0], PAD_BIT};
               end else begin
                  shift_nxt_s = PAD_WORD_C;
               end
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            shift_nxt_s = PAD_WORD_C;
            if (cs_rise_s) begin
               state_nxt_s  = ST_IDLE;
               sio_oe_nxt_s = 1'b0;
               busy_nxt_s   = 1'b0;
               done_nxt_s   = 1'b1;
            end else if (sck_rise_s) begin
               overrun_nxt_s = 1'b1;
               bit_cnt_nxt_s = FRAME_BITS_C;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            sio_oe_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge SYSCLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r   <= ST_IDLE;
         shift_r   <= '0;
         sio_oe_r  <= 1'b0;
         busy_r    <= 1'b0;
         bit_cnt_r <= 5'd0;
         done_r    <= 1'b0;
         abort_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shift_r   <= shift_nxt_s;
         sio_oe_r  <= sio_oe_nxt_s;
         busy_r    <= busy_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         done_r    <= done_nxt_s;
         abort_r   <= abort_nxt_s;
         overrun_r <= overrun_nxt_s;
      end
   end

   assign bus.SIO     = shift_r[DATA_BITS-1];
   assign bus.SIO_OE  = sio_oe_r;
   assign BUSY        = busy_r;
   assign BIT_CNT     = bit_cnt_r;
   assign FRAME_DONE  = done_r;
   assign FRAME_ABORT = abort_r;
   assign OVERRUN     = overrun_r;

endmodule

// File: tb/tb_lm07_sensor_model.sv
// Directed bench for lm07_sensor_model. The master SCK runs at SYSCLK/16.
// A table of full-frame reads is applied in a loop. Hand-written sequences
// then cover snapshot, abort, overrun and reset mid-frame.
module tb_lm07_sensor_model;

   logic       SYSCLK;
   logic       RSTN;
   logic [7:0] TEMP_IN;
   logic       BUSY;
   logic [4:0] BIT_CNT;
   logic       FRAME_DONE;
   logic       FRAME_ABORT;
   logic       OVERRUN;

   lm07_sensor_model_if bus_if ();

   lm07_sensor_model dut (
      .SYSCLK      (SYSCLK),
      .RSTN        (RSTN),
      .bus         (bus_if),
      .TEMP_IN     (TEMP_IN),
      .BUSY        (BUSY),
      .BIT_CNT     (BIT_CNT),
      .FRAME_DONE  (FRAME_DONE),
      .FRAME_ABORT (FRAME_ABORT),
      .OVERRUN     (OVERRUN)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   int n_pass  = 0;
   int n_total = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;

   // Count completion/abort pulses away from the active edge.
   always @(negedge SYSCLK) begin
      if (FRAME_DONE === 1'b1) done_cnt = done_cnt + 1;
      if (FRAME_ABORT === 1'b1) abort_cnt = abort_cnt + 1;
   end

   typedef struct {
      logic [7:0] temp;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge SYSCLK);
   endtask

   task automatic one_edge();
      bus_if.SCK = 1'b1;
      wait_cyc(8);
      bus_if.SCK = 1'b0;
      wait_cyc(8);
   endtask

   // Master read: CS low, n_edges SCK cycles, SIO sampled as SCK rises.
   // TEMP_IN switches to t1 after edge chg_at (0 = never).
   task automatic run_frame(input logic [7:0] t0, input int n_edges, input int chg_at,
                            input logic [7:0] t1, input bit raise_cs,
                            output logic [31:0] rx);
      TEMP_IN   = t0;
      bus_if.CS = 1'b0;
      wait_cyc(8);
      check("oe_busy_in_frame", {30'd0, bus_if.SIO_OE, BUSY}, 32'd3);
      rx = 32'd0;
      for (int i = 0; i < n_edges; i++) begin
         rx = {rx[30:0], bus_if.SIO};
         bus_if.SCK = 1'b1;
         wait_cyc(8);
         bus_if.SCK = 1'b0;
         if (i + 1 == chg_at) TEMP_IN = t1;
         wait_cyc(8);
      end
      if (raise_cs) begin
         bus_if.CS = 1'b1;
         wait_cyc(8);
      end
   endtask

   initial begin
      logic [31:0] rx;
      int d0, a0;

      vecs[0] = '{8'h19, 8'h19};
      vecs[1] = '{8'hFF, 8'hE3};
      vecs[2] = '{8'h64, 8'h63};
      vecs[3] = '{8'hE3, 8'hE3};
      vecs[4] = '{8'hE4, 8'hE3};
      vecs[5] = '{8'h00, 8'h00};
      vecs[6] = '{8'h80, 8'h80};
      vecs[7] = '{8'h7F, 8'h63};

      RSTN       = 1'b0;
      bus_if.CS  = 1'b1;
      bus_if.SCK = 1'b0;
      TEMP_IN    = 8'h00;
      wait_cyc(3);
      check("reset_outputs",
            {24'd0, bus_if.SIO, bus_if.SIO_OE, BUSY, FRAME_DONE, FRAME_ABORT, OVERRUN, 2'b00},
            32'd0);
      check("reset_bit_cnt", {27'd0, BIT_CNT}, 32'd0);
      RSTN = 1'b1;
      wait_cyc(10);

      // Table of complete 16-edge reads.
      for (int v = 0; v < 8; v++) begin
         d0 = done_cnt;
         a0 = abort_cnt;
         run_frame(vecs[v].temp, 16, 0, 8'h00, 1'b1, rx);
         check("frame_byte", {24'd0, rx[15:8]}, {24'd0, vecs[v].exp_byte});
         check("frame_pad", {24'd0, rx[7:0]}, 32'h0000_00FF);
         check("frame_done_once", done_cnt - d0, 32'd1);
         check("frame_no_abort", abort_cnt - a0, 32'd0);
         check("frame_overrun", {31'd0, OVERRUN}, 32'd0);
         check("frame_bit_cnt", {27'd0, BIT_CNT}, 32'd16);
         check("frame_idle", {30'd0, bus_if.SIO_OE, BUSY}, 32'd0);
      end

      // Snapshot: TEMP_IN changes mid-frame, visible only in the next frame.
      run_frame(8'h10, 16, 3, 8'h20, 1'b1, rx);
      check("snap_first", {24'd0, rx[15:8]}, 32'h10);
      run_frame(8'h20, 16, 0, 8'h00, 1'b1, rx);
      check("snap_second", {24'd0, rx[15:8]}, 32'h20);

      // Abort after 5 edges.
      d0 = done_cnt;
      a0 = abort_cnt;
      run_frame(8'h33, 5, 0, 8'h00, 1'b0, rx);
      check("abort_bits", {27'd0, rx[4:0]}, {27'd0, 5'b00110});
      bus_if.CS = 1'b1;
      wait_cyc(4);
      check("abort_oe_off", {31'd0, bus_if.SIO_OE}, 32'd0);
      wait_cyc(20);
      check("abort_pulse", abort_cnt - a0, 32'd1);
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_cnt_hold", {27'd0, BIT_CNT}, 32'd5);

      // Overrun: 16 edges, then 2 more with CS still low.
      d0 = done_cnt;
      run_frame(8'h19, 16, 0, 8'h00, 1'b0, rx);
      check("ovr_before", {31'd0, OVERRUN}, 32'd0);
      one_edge();
      check("ovr_17th", {31'd0, OVERRUN}, 32'd1);
      check("ovr_sio", {31'd0, bus_if.SIO}, 32'd1);
      one_edge();
      check("ovr_cnt_sat", {27'd0, BIT_CNT}, 32'd16);
      bus_if.CS = 1'b1;
      wait_cyc(8);
      check("ovr_done", done_cnt - d0, 32'd1);
      check("ovr_sticky", {31'd0, OVERRUN}, 32'd1);
      bus_if.CS = 1'b0;
      wait_cyc(8);
      check("ovr_clear", {31'd0, OVERRUN}, 32'd0);
      check("ovr_cnt_clear", {27'd0, BIT_CNT}, 32'd0);
      bus_if.CS = 1'b1;
      wait_cyc(8);

      // Reset mid-frame with CS held low.
      d0 = done_cnt;
      a0 = abort_cnt;
      run_frame(8'h55, 4, 0, 8'h00, 1'b0, rx);
      RSTN = 1'b0;
      #1;
      check("rst_mid_oe", {31'd0, bus_if.SIO_OE}, 32'd0);
      check("rst_mid_state", {25'd0, BUSY, BIT_CNT, OVERRUN}, 32'd0);
      wait_cyc(3);
      RSTN = 1'b1;
      wait_cyc(10);
      one_edge();
      one_edge();
      check("rst_no_new_frame", {30'd0, BUSY, bus_if.SIO_OE}, 32'd0);
      check("rst_cnt_zero", {27'd0, BIT_CNT}, 32'd0);
      bus_if.CS = 1'b1;
      wait_cyc(8);
      check("rst_no_done", done_cnt - d0, 32'd0);
      check("rst_no_abort", abort_cnt - a0, 32'd0);
      run_frame(8'h2A, 16, 0, 8'h00, 1'b1, rx);
      check("rst_clean_byte", {24'd0, rx[15:8]}, 32'h2A);
      check("rst_clean_done", done_cnt - d0, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
